ripple_count_capture: RTL and testbench
=======================================

// Module: ripple_count_capture
// PURPOSE
//  Downstream consumer of the 3-bit JK ripple counter. Brings the counter's asynchronous q bus into the
//  system clk domain, rejects ripple-settling glitches, converts successive values into increments, and
//  accumulates them into a wide count. Raises a valid/ready snapshot when a programmable threshold is reached.
// PARAMETERS
//  CNT_W        3   width of ripple counter bus rip_q
//  ACC_W        16  accumulator / snapshot width (ACC_W > CNT_W)
//  SYNC_STAGES  2   flops in synchronizer chain (>=2)
// PORTS
//  clk        in   1      system clock, all state on posedge
//  clr        in   1      asynchronous reset, active low
//  enable     in   1      1 = capture/accumulate; 0 = return to IDLE (acc retained)
//  rip_q      in   CNT_W  ripple counter outputs, asynchronous to clk
//  acc_clear  in   1      synchronous clear of acc and overflow; ignored in HOLD
//  thresh     in   ACC_W  snapshot threshold; 0 = snapshots disabled
//  acc        out  ACC_W  running accumulated count
//  delta      out  CNT_W  increment accepted this cycle (0 when none)
//  out_valid  out  1      snapshot available (HOLD)
//  out_ready  in   1      consumer accepts snapshot
//  snap       out  ACC_W  snapshot value, stable while out_valid=1
//  overflow   out  1      accumulator overflow indicator (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (clr=0, async): sync chain=0, stable=0, last=0, acc=0, delta=0, snap=0, out_valid=0,
//    overflow=0, state=IDLE.
//  - Sync: rip_q -> SYNC_STAGES flops -> s. Filter: sample accepted as stable value v only when s equals
//    previous-cycle s (two consecutive equal samples). Latency rip_q change -> v: SYNC_STAGES+1 clks.
//  - Increment: d = (v - last) mod 2^CNT_W, computed only when a new v is accepted and v != last; last <= v.
//    Wrap 7->0 (CNT_W=3) gives d=1. d is zero-extended and added to acc in the same cycle.
//  - FSM:
//    IDLE: delta=0, acc holds. enable=1 -> ARM.
//    ARM : first accepted v loads last, no accumulation (baseline). -> RUN.
//    RUN : accumulate d. If thresh!=0 and acc_next >= thresh: snap <= acc_next, acc <= 0, out_valid <= 1,
//          -> HOLD. enable=0 -> IDLE.
//    HOLD: keep accumulating into acc; snap and out_valid held. out_valid&&out_ready -> out_valid <= 0,
//          -> RUN (or IDLE if enable=0 that cycle). enable=0 alone does not drop a pending snapshot.
//  - acc_clear in RUN: acc <= 0, overflow <= 0; a d accepted in the same cycle is discarded.
//  - Re-entry from IDLE always passes through ARM (no stale delta across disable).
//  - Changing thresh takes effect on the next compare; no retroactive snapshot.
// CONFIGURATION
//  ACC_SATURATE_EN defined: acc+d beyond 2^ACC_W-1 clamps at all-ones; overflow set sticky until
//   acc_clear or reset.
//  ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W; overflow is a one-clk pulse on the wrapping add.
// TESTING
//  1 Reset: clr=0 mid-RUN with acc=5 -> all outputs 0 immediately, state IDLE.
//  2 Count: enable=1, rip_q steps 0..7 spaced 8 clks -> after baseline, acc=7; each step delta=1.
//  3 Wrap: rip_q 6->7->0->1 -> three delta=1 pulses, acc +3.
//  4 Glitch: rip_q 3->2(1 clk)->4 -> 2 rejected, single delta=1, acc +1.
//  5 Handshake: thresh=4, four steps -> out_valid=1, snap=4, acc=0; out_ready low 10 clks with
//    2 more steps -> snap stays 4, acc=2; out_ready=1 -> out_valid=0 next clk.
//  6 Overflow: ACC_W=4, acc=14, steps of d=3 -> SATURATE_EN: acc=15, overflow=1 sticky;
//    without: acc=1, overflow pulses one clk.

Source files
------------

// File: rtl/ripple_count_capture.sv
// Captures an asynchronous ripple-counter bus, filters settling glitches and accumulates the increments.
// Build option ACC_SATURATE_EN: saturate the accumulator with a sticky overflow flag (default: wrap + pulse).
module ripple_count_capture #(
    parameter int CNT_W       = 3,
    parameter int ACC_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [CNT_W-1:0] rip_q,
    input  logic             acc_clear,
    input  logic [ACC_W-1:0] thresh,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] delta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] snap,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, HOLD} state_t;

    state_t                              state;
    logic [SYNC_STAGES-1:0][CNT_W-1:0]   sync;
    logic [CNT_W-1:0]                    stable;
    logic [CNT_W-1:0]                    last;

    logic [CNT_W-1:0] s;
    logic             qual;
    logic             newv;
    logic [CNT_W-1:0] d;
    logic [ACC_W:0]   sum;
    logic             wrap;
    logic [ACC_W-1:0] acc_next;
    logic             hit;

    // A sample is trusted only once it has held for two consecutive clocks.
    always_comb begin
        s    = sync[SYNC_STAGES-1];
        qual = (s == stable);
        newv = qual && (s != last);
        d    = s - last;
        sum  = {1'b0, acc} + {{(ACC_W+1-CNT_W){1'b0}}, d};
        wrap = sum[ACC_W];
`ifdef ACC_SATURATE_EN
        acc_next = wrap ? '1 : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
        hit = (thresh != '0) && (acc_next >= thresh);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            sync      <= '0;
            stable    <= '0;
            last      <= '0;
            acc       <= '0;
            delta     <= '0;
            snap      <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], rip_q};
            stable <= s;
            delta  <= '0;
`ifndef ACC_SATURATE_EN
            overflow <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (acc_clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                    if (enable) state <= ARM;
                end
                ARM: begin
                    if (acc_clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                    if (!enable) state <= IDLE;
                    else if (qual) begin
                        last  <= s;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) state <= IDLE;
                    else if (acc_clear) begin
                        // An increment landing with the clear is dropped, but the baseline still moves.
                        acc      <= '0;
                        overflow <= 1'b0;
                        if (qual) last <= s;
                    end else if (newv) begin
                        delta <= d;
                        last  <= s;
`ifdef ACC_SATURATE_EN
                        if (wrap) overflow <= 1'b1;
`else
                        overflow <= wrap;
`endif
                        if (hit) begin
                            snap      <= acc_next;
                            acc       <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            acc <= acc_next;
                        end
                    end
                end
                HOLD: begin
                    if (newv) begin
                        delta <= d;
                        last  <= s;
                        acc   <= acc_next;
`ifdef ACC_SATURATE_EN
                        if (wrap) overflow <= 1'b1;
`else
                        overflow <= wrap;
`endif
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= enable ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench: 16-bit instance for counting/handshake/reset, 4-bit instance for overflow behaviour.
module tb_ripple_count_capture;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  rip = '0;
    logic        acc_clear = 1'b0;
    logic [15:0] thresh = '0;
    logic        out_ready = 1'b0;
    logic [15:0] acc, snap;
    logic [2:0]  delta;
    logic        out_valid, overflow;

    logic        en4 = 1'b0;
    logic [2:0]  rip4 = '0;
    logic        clear4 = 1'b0;
    logic [3:0]  acc4, snap4;
    logic [2:0]  delta4;
    logic        valid4, ovf4;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];
    logic [2:0] mlast = '0;

    always #5 clk = ~clk;

    ripple_count_capture dut (
        .clk(clk), .clr(clr), .enable(enable), .rip_q(rip), .acc_clear(acc_clear),
        .thresh(thresh), .acc(acc), .delta(delta), .out_valid(out_valid),
        .out_ready(out_ready), .snap(snap), .overflow(overflow)
    );

    ripple_count_capture #(.CNT_W(3), .ACC_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .clr(clr), .enable(en4), .rip_q(rip4), .acc_clear(clear4),
        .thresh(4'd0), .acc(acc4), .delta(delta4), .out_valid(valid4),
        .out_ready(1'b0), .snap(snap4), .overflow(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every nonzero delta must match the oldest expected increment.
    always @(negedge clk) begin
        if (clr && delta !== 3'd0) begin
            check("delta_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) check("delta_value", {29'd0, delta}, {29'd0, sb.pop_front()});
        end
    end

    task automatic step(input logic [2:0] v, input bit counting);
        @(negedge clk);
        rip = v;
        if (counting && v != mlast) sb.push_back(v - mlast);
        mlast = v;
        repeat (8) @(negedge clk);
    endtask

    task automatic step4(input logic [2:0] v, output int ovf_cycles);
        ovf_cycles = 0;
        @(negedge clk);
        rip4 = v;
        repeat (8) begin
            @(negedge clk);
            if (ovf4) ovf_cycles++;
        end
    endtask

    initial begin
        int oc;
        // Reset state
        #12;
        check("rst_acc", {16'd0, acc}, 32'd0);
        check("rst_delta", {29'd0, delta}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_snap", {16'd0, snap}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk); clr = 1'b1;
        repeat (3) @(negedge clk);

        // Count 0..7 after baseline
        enable = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 1; i <= 7; i++) step(i[2:0], 1'b1);
        check("count_acc", {16'd0, acc}, 32'd7);

        // Disable, move while idle, re-arm: no stale increment
        @(negedge clk); enable = 1'b0;
        step(3'd6, 1'b0);
        check("idle_acc", {16'd0, acc}, 32'd7);
        @(negedge clk); enable = 1'b1;
        repeat (8) @(negedge clk);
        check("rearm_acc", {16'd0, acc}, 32'd7);

        // Wrap 6->7->0->1
        step(3'd7, 1'b1);
        step(3'd0, 1'b1);
        step(3'd1, 1'b1);
        check("wrap_acc", {16'd0, acc}, 32'd10);

        // Glitch 3 -> 2 (one clock) -> 4
        step(3'd3, 1'b1);
        check("pre_glitch_acc", {16'd0, acc}, 32'd12);
        @(negedge clk); rip = 3'd2;
        @(negedge clk); rip = 3'd4;
        sb.push_back(3'd1);
        mlast = 3'd4;
        repeat (8) @(negedge clk);
        check("glitch_acc", {16'd0, acc}, 32'd13);
        check("glitch_sb_drained", sb.size(), 32'd0);

        // Synchronous clear
        @(negedge clk); acc_clear = 1'b1;
        @(negedge clk); acc_clear = 1'b0;
        @(negedge clk);
        check("clear_acc", {16'd0, acc}, 32'd0);

        // Threshold snapshot and held handshake
        thresh = 16'd4;
        step(3'd5, 1'b1);
        step(3'd6, 1'b1);
        step(3'd7, 1'b1);
        check("pre_snap_valid", {31'd0, out_valid}, 32'd0);
        step(3'd0, 1'b1);
        check("snap_valid", {31'd0, out_valid}, 32'd1);
        check("snap_value", {16'd0, snap}, 32'd4);
        check("snap_acc", {16'd0, acc}, 32'd0);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_snap", {16'd0, snap}, 32'd4);
        check("hold_acc", {16'd0, acc}, 32'd2);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk);
        check("ack_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        thresh = 16'd0;

        // Asynchronous reset mid-RUN with acc=5
        step(3'd3, 1'b1);
        step(3'd4, 1'b1);
        step(3'd5, 1'b1);
        check("prereset_acc", {16'd0, acc}, 32'd5);
        check("sb_drained", sb.size(), 32'd0);
        @(negedge clk); #2 clr = 1'b0;
        #1;
        check("async_acc", {16'd0, acc}, 32'd0);
        check("async_snap", {16'd0, snap}, 32'd0);
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_delta", {29'd0, delta}, 32'd0);
        enable = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        clr = 1'b1;

        // Overflow on 4-bit accumulator: 14 then +3 twice
        repeat (2) @(negedge clk);
        en4 = 1'b1;
        repeat (8) @(negedge clk);
        step4(3'd7, oc);
        step4(3'd6, oc);
        check("ovf_pre_acc", {28'd0, acc4}, 32'd14);
        check("ovf_pre_flag", {31'd0, ovf4}, 32'd0);
        step4(3'd1, oc);
`ifdef ACC_SATURATE_EN
        check("sat_acc", {28'd0, acc4}, 32'd15);
        check("sat_flag", {31'd0, ovf4}, 32'd1);
        step4(3'd4, oc);
        check("sat_acc2", {28'd0, acc4}, 32'd15);
        check("sat_sticky", {31'd0, ovf4}, 32'd1);
`else
        check("wrap_acc4", {28'd0, acc4}, 32'd1);
        check("wrap_pulse_cycles", oc, 32'd1);
        check("wrap_flag_low", {31'd0, ovf4}, 32'd0);
        step4(3'd4, oc);
        check("wrap_acc4_2", {28'd0, acc4}, 32'd4);
        check("wrap_no_pulse", oc, 32'd0);
`endif
        @(negedge clk); clear4 = 1'b1;
        @(negedge clk); clear4 = 1'b0;
        @(negedge clk);
        check("clear4_acc", {28'd0, acc4}, 32'd0);
        check("clear4_ovf", {31'd0, ovf4}, 32'd0);
        check("main_ovf_quiet", {31'd0, overflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
